dmg_timer_div: RTL

- Parametrised successor of the DMG clock-divider/DIV chain.
- Provides a synchronous free-running divider with a CPU-visible DIV byte, a programmable timer counter (TIMA), a modulo register (TMA) and a control register (TAC) with selectable divider taps.
- Raises a one-clock interrupt request on timer overflow.
- Sits between the clock/reset block (4 MHz clk, nreset) and the CPU bus / interrupt controller.

---
 rtl/dmg_timer_div.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmg_timer_div.sv
// dmg_timer_div: free-running clock divider with a CPU-visible DIV byte, plus a programmable
// timer (TIMA) with modulo reload (TMA), a control register (TAC) and an overflow interrupt.
//
// Ports:
//   clk      system clock
//   nreset   asynchronous active-low reset
//   addr     register select: 0 DIV, 1 TIMA, 2 TMA, 3 TAC
//   wr       write strobe, one clk per access
//   rd       read strobe
//   wdata    write data
//   rdata    read data, combinational from addr; 0 when rd=0 or in reset
//   irq      timer interrupt request, one-clk pulse
//   div_tap  raw divider bits selected by each TAP_LIST entry (unregistered)
//
// Optional feature macro: TIMER_RELOAD_DELAY_EN
//   defined   - overflow leaves TIMA at 0 for one clk (PEND) before the TMA reload and irq
//   undefined - overflow reloads TMA and raises irq straight away
module dmg_timer_div #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TAP_SEL_W = 2,
    parameter logic [5*(2**TAP_SEL_W)-1:0] TAP_LIST = {5'd7, 5'd5, 5'd3, 5'd9},
    parameter logic        TAC_PAD   = 1'b1
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [1:0]              addr,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [CNT_W-1:0]        wdata,
    output logic [CNT_W-1:0]        rdata,
    output logic                    irq,
    output logic [2**TAP_SEL_W-1:0] div_tap
);

    localparam int unsigned NumTaps = 2**TAP_SEL_W;
    localparam int unsigned TacW    = TAP_SEL_W + 1;

    // StReload is the clk in which TIMA shows the reloaded TMA value and irq is high.
    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StReload
    } state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] tima_q, tima_d;
    logic [CNT_W-1:0] tma_q, tma_d;
    logic [TacW-1:0]  tac_q, tac_d;
    logic             t_in_q, t_in_d;
    logic             irq_q, irq_d;
    state_e           state_q, state_d;

    logic wr_div, wr_tima, wr_tma, wr_tac;
    logic t_in, inc;

    assign wr_div  = wr && (addr == 2'd0);
    assign wr_tima = wr && (addr == 2'd1);
    assign wr_tma  = wr && (addr == 2'd2);
    assign wr_tac  = wr && (addr == 2'd3);

    always_comb begin
        logic [DIV_W-1:0] shifted;
        div_tap = '0;
        shifted = '0;
        for (int k = 0; k < NumTaps; k++) begin
            shifted    = div_q >> TAP_LIST[5*k +: 5];
            div_tap[k] = shifted[0];
        end
    end

    // Timer input and its clk-to-clk falling-edge detector. Edges caused by a DIV clear or a
    // TAC write are indistinguishable from ordinary ones and count the same way.
    assign t_in = tac_q[TAP_SEL_W] & div_tap[tac_q[TAP_SEL_W-1:0]];
    assign inc  = t_in_q & ~t_in;

    always_comb begin
        div_d   = wr_div ? '0 : div_q + DIV_W'(1);
        tac_d   = wr_tac ? wdata[TacW-1:0] : tac_q;
        tma_d   = wr_tma ? wdata : tma_q;
        t_in_d  = t_in;
        tima_d  = tima_q;
        state_d = state_q;
        irq_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_tima) begin
                    tima_d = wdata;
                end else if (inc) begin
                    if (tima_q == '1) begin
`ifdef TIMER_RELOAD_DELAY_EN
                        tima_d  = '0;
                        state_d = StPend;
`else
                        // A TMA write in the overflow clk supplies the reload value.
                        tima_d  = tma_d;
                        irq_d   = 1'b1;
`endif
                    end else begin
                        tima_d = tima_q + CNT_W'(1);
                    end
                end
            end
            StPend: begin
                // Increment edges are dropped here; a TIMA write cancels reload and irq.
                if (wr_tima) begin
                    tima_d  = wdata;
                    state_d = StIdle;
                end else begin
                    tima_d  = tma_d;
                    irq_d   = 1'b1;
                    state_d = StReload;
                end
            end
            StReload: begin
                // TMA writes pass straight through to TIMA; TIMA writes and increments are lost.
                if (wr_tma) begin
                    tima_d = wdata;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_q   <= '0;
            tima_q  <= '0;
            tma_q   <= '0;
            tac_q   <= '0;
            t_in_q  <= 1'b0;
            irq_q   <= 1'b0;
            state_q <= StIdle;
        end else begin
            div_q   <= div_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            t_in_q  <= t_in_d;
            irq_q   <= irq_d;
            state_q <= state_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        rdata = '0;
        if (rd && nreset) begin
            case (addr)
                2'd0: rdata = div_q[DIV_W-1 -: CNT_W];
                2'd1: rdata = tima_q;
                2'd2: rdata = tma_q;
                default: rdata = {{(CNT_W-TacW){TAC_PAD}}, tac_q};
            endcase
        end
    end

endmodule
